vga_rd_dma: RTL and testbench

Read-side DMA for the image coprocessor: on `start` it fetches one IMG_W×IMG_H image from the FB_W-wide frame buffer and streams it, row-major, to the coprocessor input as a valid/ready pixel stream. The image is taken from either the left half (base 0) or the right half (base IMG_W) of the frame buffer. It is the counterpart of the coprocessor's frame-buffer write DMA and uses the same address striding. The frame-buffer read port has a fixed 1-cycle synchronous read latency, so the block carries a 2-entry skid FIFO to sustain 1 pixel/cycle under back-pressure.

---
 rtl/vga_rd_dma.sv | 158 +++++++++++++++
 tb/tb_vga_rd_dma.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rd_dma.sv
// Read-side frame-buffer DMA: streams one IMG_W x IMG_H image as a valid/ready pixel stream.
// Optional sof/eol stream markers are enabled by defining VGA_RD_MARKERS_EN.
module vga_rd_dma #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int FB_W  = 512,
    parameter int AW    = 17,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          src_sel,
    output logic          rd_en,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          busy,
    output logic          done
`ifdef VGA_RD_MARKERS_EN
    ,
    output logic          sof,
    output logic          eol
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
`ifdef VGA_RD_MARKERS_EN
    localparam int EW = DW + 2;
`else
    localparam int EW = DW;
`endif
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_W - IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          inflight;
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic [2:0]    occ;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [EW-1:0] mem [2];
    logic [EW-1:0] wr_data;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          last_rd;

    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid & pix_ready;
    assign push      = inflight;
    assign busy      = (state != IDLE);

    // Occupancy seen by the issue logic: stored + in flight, net of this cycle's pop.
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en     = (state == RUN) && (occ < 3'd2);
    assign last_rd   = rd_en && (col == COL_LAST) && (row == ROW_LAST);
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    assign head      = mem[rd_ptr];
    assign pix_data  = head[DW-1:0];

`ifdef VGA_RD_MARKERS_EN
    logic sof_q;
    logic eol_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_q <= 1'b0;
            eol_q <= 1'b0;
        end else begin
            sof_q <= rd_en && (row == '0) && (col == '0);
            eol_q <= rd_en && (col == COL_LAST);
        end
    end

    assign wr_data = {sof_q, eol_q, rdata};
    assign sof     = head[DW+1];
    assign eol     = head[DW];
`else
    assign wr_data = rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            raddr    <= '0;
            col      <= '0;
            row      <= '0;
            done     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rd_en;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        raddr <= src_sel ? AW'(IMG_W) : '0;
                        col   <= '0;
                        row   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        if (col == COL_LAST) begin
                            raddr <= raddr + ROW_STEP;
                            col   <= '0;
                            row   <= row + RW'(1);
                        end else begin
                            raddr <= raddr + AW'(1);
                            col   <= col + CW'(1);
                        end
                    end
                    if (last_rd) state <= DRAIN;
                end
                DRAIN: begin
                    if (count_nxt == 2'd0 && !inflight) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_nxt;
        end
    end

    // The issue throttle makes a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && !pop && count == 2'd2));
    end

endmodule

// File: tb/tb_vga_rd_dma.sv
// Self-checking bench for vga_rd_dma with a reduced image geometry.
module tb_vga_rd_dma;

    localparam int IW = 16;
    localparam int IH = 4;
    localparam int FW = 32;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int N  = IW * IH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          src_sel = 1'b0;
    logic          rd_en;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          busy;
    logic          done;
`ifdef VGA_RD_MARKERS_EN
    logic          sof;
    logic          eol;
`endif

    logic [DW-1:0] fb [1<<AW];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rdata <= fb[raddr];

    vga_rd_dma #(
        .IMG_W(IW), .IMG_H(IH), .FB_W(FW), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .src_sel(src_sel),
        .rd_en(rd_en),
        .raddr(raddr),
        .rdata(rdata),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy(busy),
        .done(done)
`ifdef VGA_RD_MARKERS_EN
        ,
        .sof(sof),
        .eol(eol)
`endif
    );

    // Frame runner: gathers statistics against the row-major address model.
    task automatic run_frame(
        input  bit sel, input int pct, input int stray,
        output int xfers, output int data_bad, output int addr_bad,
        output int done_cyc, output int last_cyc, output int stall_bad,
        output int max_out, output int mark_bad, output bit busy_done
    );
        int base;
        int reads;
        bit pv;
        bit pr;
        logic [DW-1:0] pd;
        base = sel ? IW : 0;
        reads = 0; pv = 0; pr = 0; pd = '0;
        xfers = 0; data_bad = 0; addr_bad = 0; done_cyc = -1;
        last_cyc = -1; stall_bad = 0; max_out = 0; mark_bad = 0;
        busy_done = 1'b1;
        start = 1'b1;
        src_sel = sel;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 20 * N; k++) begin
            if (k == stray) begin
                start = 1'b1;
                src_sel = !sel;
            end else begin
                start = 1'b0;
            end
            pix_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (reads - xfers > max_out) max_out = reads - xfers;
            if (pv && !pr && (!pix_valid || pix_data !== pd)) stall_bad++;
            if (rd_en) begin
                int a;
                a = base + (reads / IW) * FW + reads % IW;
                if (reads >= N || raddr !== AW'(a)) addr_bad++;
                reads++;
            end
            if (pix_valid && pix_ready) begin
                int a;
                a = base + (xfers / IW) * FW + xfers % IW;
                if (xfers >= N || pix_data !== fb[a % (1 << AW)]) data_bad++;
`ifdef VGA_RD_MARKERS_EN
                if (sof !== (xfers == 0) || eol !== (xfers % IW == IW - 1))
                    mark_bad++;
`endif
                xfers++;
                last_cyc = k;
            end
            pv = pix_valid;
            pr = pix_ready;
            pd = pix_data;
            if (done) begin
                done_cyc = k;
                busy_done = busy;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({rd_en, raddr, pix_valid, pix_data, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got rd=%b a=%0d v=%b d=%0h b=%b dn=%b want all 0",
                     rd_en, raddr, pix_valid, pix_data, busy, done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({rd_en, raddr, pix_valid, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle got rd=%b a=%0d v=%b b=%b dn=%b want all 0",
                     rd_en, raddr, pix_valid, busy, done);
        end
    endtask

    task automatic test_first_cycles;
        int seen;
        pix_ready = 1'b1;
        start = 1'b1;
        src_sel = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        vectors++;
        if ({busy, rd_en, raddr} !== {1'b1, 1'b1, AW'(IW)}) begin
            miscompares++;
            $display("FAIL cycle1 got b=%b rd=%b a=%0d want 1 1 %0d", busy, rd_en, raddr, IW);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cycle2_valid got %b want 0", pix_valid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pix_valid !== 1'b1 || pix_data !== fb[IW]) begin
            miscompares++;
            $display("FAIL cycle3 got v=%b d=%0h want 1 %0h", pix_valid, pix_data, fb[IW]);
        end
        seen = 0;
        for (int k = 0; k < 20 * N && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        vectors++;
        if (seen != 1) begin
            miscompares++;
            $display("FAIL first_done got %0d want 1", seen);
        end
    endtask

    task automatic test_left;
        int x, db, ab, dc, lc, sb, mo, mb;
        bit bd;
        run_frame(1'b0, 100, -1, x, db, ab, dc, lc, sb, mo, mb, bd);
        vectors++;
        if (x != N || db != 0 || ab != 0) begin
            miscompares++;
            $display("FAIL left_stream got x=%0d db=%0d ab=%0d want %0d 0 0", x, db, ab, N);
        end
        vectors++;
        if (lc != N + 2 || dc != N + 3 || bd !== 1'b0) begin
            miscompares++;
            $display("FAIL left_timing got last=%0d done=%0d busy=%b want %0d %0d 0",
                     lc, dc, bd, N + 2, N + 3);
        end
`ifdef VGA_RD_MARKERS_EN
        vectors++;
        if (mb != 0) begin
            miscompares++;
            $display("FAIL left_markers got %0d bad want 0", mb);
        end
`endif
    endtask

    task automatic test_right;
        int x, db, ab, dc, lc, sb, mo, mb;
        bit bd;
        run_frame(1'b1, 100, -1, x, db, ab, dc, lc, sb, mo, mb, bd);
        vectors++;
        if (x != N || db != 0 || ab != 0 || mb != 0) begin
            miscompares++;
            $display("FAIL right_stream got x=%0d db=%0d ab=%0d mb=%0d want %0d 0 0 0",
                     x, db, ab, mb, N);
        end
        vectors++;
        if (dc != N + 3) begin
            miscompares++;
            $display("FAIL right_done got %0d want %0d", dc, N + 3);
        end
    endtask

    task automatic test_random_ready;
        int x, db, ab, dc, lc, sb, mo, mb;
        bit bd;
        for (int f = 0; f < 3; f++) begin
            run_frame(1'($urandom_range(1)), 50, -1, x, db, ab, dc, lc, sb, mo, mb, bd);
            vectors++;
            if (x != N || db != 0 || ab != 0 || mb != 0 || dc < 0) begin
                miscompares++;
                $display("FAIL rand_stream%0d got x=%0d db=%0d ab=%0d mb=%0d dc=%0d want %0d 0 0 0 >=0",
                         f, x, db, ab, mb, dc, N);
            end
            vectors++;
            if (sb != 0 || mo > 2) begin
                miscompares++;
                $display("FAIL rand_stall%0d got stall=%0d occ=%0d want 0 <=2", f, sb, mo);
            end
        end
    endtask

    task automatic test_stray_start;
        int x, db, ab, dc, lc, sb, mo, mb;
        bit bd;
        run_frame(1'b0, 100, 40, x, db, ab, dc, lc, sb, mo, mb, bd);
        vectors++;
        if (x != N || db != 0 || ab != 0 || dc != N + 3) begin
            miscompares++;
            $display("FAIL stray_start got x=%0d db=%0d ab=%0d dc=%0d want %0d 0 0 %0d",
                     x, db, ab, dc, N, N + 3);
        end
    endtask

    task automatic test_back_to_back;
        int x, db, ab, dc, lc, sb, mo, mb;
        bit bd;
        run_frame(1'b0, 100, -1, x, db, ab, dc, lc, sb, mo, mb, bd);
        vectors++;
        if (dc != N + 3) begin
            miscompares++;
            $display("FAIL b2b_first got done=%0d want %0d", dc, N + 3);
        end
        run_frame(1'b1, 100, -1, x, db, ab, dc, lc, sb, mo, mb, bd);
        vectors++;
        if (x != N || db != 0 || ab != 0 || dc != N + 3) begin
            miscompares++;
            $display("FAIL b2b_second got x=%0d db=%0d ab=%0d dc=%0d want %0d 0 0 %0d",
                     x, db, ab, dc, N, N + 3);
        end
    endtask

    task automatic test_reset_mid;
        int x, db, ab, dc, lc, sb, mo, mb;
        int hit;
        bit bd;
        hit = 0;
        pix_ready = 1'b1;
        start = 1'b1;
        src_sel = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 20 * N && !hit; k++) begin
            @(negedge clk);
            if (rd_en && raddr == AW'(2 * FW + 5)) hit = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        vectors++;
        if (hit != 1) begin
            miscompares++;
            $display("FAIL mid_reach got %0d want 1", hit);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rd_en, raddr, pix_valid, pix_data, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got rd=%b a=%0d v=%b d=%0h b=%b dn=%b want all 0",
                     rd_en, raddr, pix_valid, pix_data, busy, done);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1'b0, 100, -1, x, db, ab, dc, lc, sb, mo, mb, bd);
        vectors++;
        if (x != N || db != 0 || ab != 0 || dc != N + 3) begin
            miscompares++;
            $display("FAIL mid_restart got x=%0d db=%0d ab=%0d dc=%0d want %0d 0 0 %0d",
                     x, db, ab, dc, N, N + 3);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) fb[i] = DW'($urandom);
        test_reset();
        test_first_cycles();
        test_left();
        test_right();
        test_random_ready();
        test_stray_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
